operand_accumulator: RTL and testbench

Streaming multi-operand accumulator that sits directly around the team's 64-bit combinational adders. It feeds operand pairs into an external adder (running sum plus incoming word) and consumes the adder's sum back into its accumulator register. It accepts a programmed-length burst of words over a valid/ready input and presents the final sum, plus an unsigned-overflow flag, over a valid/ready output. Any adder variant with the same `num1_i/num2_i/sum_o` shape can be attached without changing this block.

---
 rtl/operand_accumulator_pkg.sv | 11 +
 rtl/operand_accumulator_if.sv | 28 ++
 rtl/operand_accumulator_selfcheck.sv | 46 ++++
 rtl/operand_accumulator.sv | 101 ++++++++++
 tb/tb_operand_accumulator.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/operand_accumulator_pkg.sv
// operand_accumulator_pkg: types and constants shared by the accumulator
// top, its interface users and the optional self-check sub-module.
package operand_accumulator_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int ERR_CNT_W = 16;
endpackage

// File: rtl/operand_accumulator_if.sv
// operand_accumulator_if: input word stream, result stream and external
// adder operand/sum bus of the accumulator.
//   slave  : accumulator side (drives in_ready_o, add_a_o/add_b_o, res_*_o)
//   master : surrounding logic side (drives words, adder sum, res_ready_i)
interface operand_accumulator_if #(
  parameter int WIDTH = 64
);
  logic             in_valid_i;
  logic [WIDTH-1:0] in_data_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] add_a_o;
  logic [WIDTH-1:0] add_b_o;
  logic [WIDTH-1:0] add_sum_i;
  logic             res_valid_o;
  logic [WIDTH-1:0] res_data_o;
  logic             res_ovf_o;
  logic             res_ready_i;

  modport slave (
    input  in_valid_i, in_data_i, add_sum_i, res_ready_i,
    output in_ready_o, add_a_o, add_b_o, res_valid_o, res_data_o, res_ovf_o
  );

  modport master (
    output in_valid_i, in_data_i, add_sum_i, res_ready_i,
    input  in_ready_o, add_a_o, add_b_o, res_valid_o, res_data_o, res_ovf_o
  );
endinterface

// File: rtl/operand_accumulator_selfcheck.sv
// acc_selfcheck: recomputes the external adder's sum on each accepted beat
// and flags disagreement.
//   i_clr        : clear flag and counter (accepted start)
//   i_beat       : a word is being consumed this cycle
//   i_a/i_b/i_sum: operands sent to the adder and the sum it returned
//   o_err        : sticky mismatch flag
//   o_err_cnt    : saturating mismatch count
module acc_selfcheck
  import operand_accumulator_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_clr,
  input  logic                 i_beat,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [WIDTH-1:0]     i_sum,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);
  logic [WIDTH-1:0]     w_ref;
  logic                 w_mis;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_cnt;

  assign w_ref = i_a + i_b;
  assign w_mis = i_beat & (i_sum != w_ref);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_mis) begin
      r_err <= 1'b1;
      if (r_cnt != '1) r_cnt <= r_cnt + ERR_CNT_W'(1);
    end
  end

  assign o_err     = r_err;
  assign o_err_cnt = r_cnt;
endmodule

// File: rtl/operand_accumulator.sv
// operand_accumulator: accumulates a programmed-length burst of words using
// an external combinational adder (acc + word) and returns the final sum
// plus an unsigned-overflow flag over a valid/ready result port.
//   clk_i, rst_ni  : clock, async active-low reset
//   start_i, len_i : begin a burst of len_i words (sampled in IDLE only)
//   bus (slave)    : input stream, adder operands/sum, result stream
//   busy_o         : not IDLE
//   err_o/err_cnt_o: adder self-check flag/count; live only when built with
//                    the ACC_SELFCHECK_EN macro, otherwise tied to 0
module operand_accumulator
  import operand_accumulator_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       len_i,
  operand_accumulator_if.slave   bus,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);
  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_rem;
  logic             w_start, w_beat, w_in_ready, w_res_valid;

  // start is only honoured in IDLE, so a start coinciding with the DONE
  // handshake is dropped.
  assign w_start = (r_state == ST_IDLE) & start_i;
  assign w_beat  = w_in_ready & bus.in_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_res_valid = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (start_i) w_state_nxt = (len_i == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid_i && r_rem == CNT_W'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_res_valid = 1'b1;
        if (bus.res_ready_i) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Overflow: a mod-2^WIDTH sum smaller than the registered acc means the
  // add wrapped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_rem <= '0;
    end else if (w_start) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_rem <= len_i;
    end else if (w_beat) begin
      r_acc <= bus.add_sum_i;
      r_ovf <= r_ovf | (bus.add_sum_i < r_acc);
      r_rem <= r_rem - CNT_W'(1);
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.res_valid_o = w_res_valid;
  assign bus.res_data_o  = r_acc;
  assign bus.res_ovf_o   = r_ovf;
  assign bus.add_a_o     = r_acc;
  assign bus.add_b_o     = bus.in_data_i;
  assign busy_o          = (r_state != ST_IDLE);

`ifdef ACC_SELFCHECK_EN
  acc_selfcheck #(.WIDTH(WIDTH)) u_selfcheck (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_clr     (w_start),
    .i_beat    (w_beat),
    .i_a       (r_acc),
    .i_b       (bus.in_data_i),
    .i_sum     (bus.add_sum_i),
    .o_err     (err_o),
    .o_err_cnt (err_cnt_o)
  );
`else
  assign err_o     = 1'b0;
  assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_operand_accumulator.sv
module tb_operand_accumulator;
  import operand_accumulator_pkg::*;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  len_i = '0;
  logic        busy_o, err_o;
  logic [15:0] err_cnt_o;
  logic        fault = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  operand_accumulator_if #(.WIDTH(64)) bus ();

  // Adder model beside the block; fault flips bit 0 of the sum.
  assign bus.add_sum_i = (bus.add_a_o + bus.add_b_o) ^ {63'b0, fault};

  operand_accumulator #(.WIDTH(64), .CNT_W(8)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .len_i     (len_i),
    .bus       (bus),
    .busy_o    (busy_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int               len;
    logic [3:0][63:0] w;
    logic [63:0]      sum;
    logic             ovf;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Back-to-back burst, res_ready_i held high; called at a negedge in IDLE.
  task automatic run_vec(input vec_t v, input string nm);
    logic [63:0] s;
    s = '0;
    bus.res_ready_i = 1'b1;
    start_i = 1'b1;
    len_i   = 8'(v.len);
    @(negedge clk_i);
    start_i = 1'b0;
    chk({nm, " in_ready_up"}, 64'(bus.in_ready_o), 64'd1);
    chk({nm, " busy"}, 64'(busy_o), 64'd1);
    chk({nm, " acc_cleared"}, bus.add_a_o, 64'd0);
    for (int i = 0; i < v.len; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = v.w[i];
      s = s + v.w[i];
      @(negedge clk_i);
      chk({nm, " running_acc"}, bus.add_a_o, s);
    end
    bus.in_valid_i = 1'b0;
    chk({nm, " res_valid"}, 64'(bus.res_valid_o), 64'd1);
    chk({nm, " res_data"}, bus.res_data_o, v.sum);
    chk({nm, " res_ovf"}, 64'(bus.res_ovf_o), 64'(v.ovf));
    chk({nm, " in_ready_done"}, 64'(bus.in_ready_o), 64'd0);
    @(negedge clk_i);
    chk({nm, " res_valid_drop"}, 64'(bus.res_valid_o), 64'd0);
    chk({nm, " idle"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    vt[0] = '{3, {64'd0, 64'd11, 64'd7, 64'd5}, 64'd23, 1'b0};
    vt[1] = '{2, {64'd0, 64'd0, 64'd2, ALL1}, 64'd1, 1'b1};
    vt[2] = '{1, {64'd0, 64'd0, 64'd0, 64'd9}, 64'd9, 1'b0};
    vt[3] = '{4, {64'd4, 64'd3, 64'd2, 64'd1}, 64'd10, 1'b0};
    vt[4] = '{2, {64'd0, 64'd0, MSB, MSB}, 64'd0, 1'b1};
    vt[5] = '{3, {64'd0, ALL1, 64'd1, ALL1}, ALL1, 1'b1};

    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 64'h1234_5678_9ABC_DEF0;
    bus.res_ready_i = 1'b0;

    // reset values
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rst in_ready", 64'(bus.in_ready_o), 64'd0);
    chk("rst res_valid", 64'(bus.res_valid_o), 64'd0);
    chk("rst res_data", bus.res_data_o, 64'd0);
    chk("rst res_ovf", 64'(bus.res_ovf_o), 64'd0);
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst add_a", bus.add_a_o, 64'd0);
    chk("rst add_b", bus.add_b_o, 64'h1234_5678_9ABC_DEF0);
    chk("rst err", 64'(err_o), 64'd0);
    chk("rst err_cnt", 64'(err_cnt_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int k = 0; k < 6; k++) run_vec(vt[k], $sformatf("vec%0d", k));

    // zero-length burst straight after an overflowing one
    bus.res_ready_i = 1'b1;
    start_i = 1'b1;
    len_i   = 8'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("len0 res_valid", 64'(bus.res_valid_o), 64'd1);
    chk("len0 res_data", bus.res_data_o, 64'd0);
    chk("len0 res_ovf", 64'(bus.res_ovf_o), 64'd0);
    chk("len0 in_ready", 64'(bus.in_ready_o), 64'd0);
    @(negedge clk_i);
    chk("len0 res_valid_drop", 64'(bus.res_valid_o), 64'd0);
    chk("len0 in_ready_after", 64'(bus.in_ready_o), 64'd0);

    // gaps between beats, result backpressure, start pulsed during DONE
    bus.res_ready_i = 1'b0;
    start_i = 1'b1;
    len_i   = 8'd4;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("gap in_ready_idle", 64'(bus.in_ready_o), 64'd1);
    chk("gap acc_hold", bus.add_a_o, 64'd0);
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 64'(i);
      @(negedge clk_i);
      bus.in_valid_i = 1'b0;
      bus.in_data_i  = 64'hDEAD_BEEF;
      @(negedge clk_i);
    end
    for (int c = 0; c < 5; c++) begin
      chk("bp res_valid", 64'(bus.res_valid_o), 64'd1);
      chk("bp res_data", bus.res_data_o, 64'd10);
      chk("bp res_ovf", 64'(bus.res_ovf_o), 64'd0);
      start_i = (c == 2);
      len_i   = 8'd2;
      @(negedge clk_i);
    end
    start_i = 1'b1;
    bus.res_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    bus.res_ready_i = 1'b0;
    chk("bp handshake res_valid", 64'(bus.res_valid_o), 64'd0);
    chk("bp handshake busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    chk("bp start_ignored busy", 64'(busy_o), 64'd0);
    chk("bp start_ignored in_ready", 64'(bus.in_ready_o), 64'd0);

    // reset after 2 of 4 beats
    start_i = 1'b1;
    len_i   = 8'd4;
    @(negedge clk_i);
    start_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 64'd100;
    @(negedge clk_i);
    bus.in_data_i  = 64'd200;
    @(negedge clk_i);
    chk("midrst acc_before", bus.add_a_o, 64'd300);
    bus.in_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("midrst in_ready", 64'(bus.in_ready_o), 64'd0);
    chk("midrst busy", 64'(busy_o), 64'd0);
    chk("midrst add_a", bus.add_a_o, 64'd0);
    chk("midrst res_valid", 64'(bus.res_valid_o), 64'd0);
    chk("midrst res_data", bus.res_data_o, 64'd0);
    chk("midrst res_ovf", 64'(bus.res_ovf_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("postrst idle", 64'(busy_o), 64'd0);
    run_vec(vt[2], "postrst");

    // faulty adder on beats 0, 1 and 3 of a 4-word burst
    bus.res_ready_i = 1'b0;
    start_i = 1'b1;
    len_i   = 8'd4;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 64'd1;
      fault = (i != 2);
      @(negedge clk_i);
    end
    bus.in_valid_i = 1'b0;
    fault = 1'b0;
    chk("sc res_valid", 64'(bus.res_valid_o), 64'd1);
`ifdef ACC_SELFCHECK_EN
    chk("sc err", 64'(err_o), 64'd1);
    chk("sc err_cnt", 64'(err_cnt_o), 64'd3);
`else
    chk("sc err_tied", 64'(err_o), 64'd0);
    chk("sc err_cnt_tied", 64'(err_cnt_o), 64'd0);
`endif
    bus.res_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1;
    len_i   = 8'd1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("sc err_clr", 64'(err_o), 64'd0);
    chk("sc err_cnt_clr", 64'(err_cnt_o), 64'd0);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 64'd5;
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    chk("sc next_data", bus.res_data_o, 64'd5);
    chk("sc next_err", 64'(err_o), 64'd0);
    @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
